// File: rtl/auto_brightness_ctrl.sv
// Auto-exposure loop: averages a fixed number of luma samples per frame and nudges the
// brightness gain level up or down when the frame mean falls outside a dead band.
module auto_brightness_ctrl #(
    parameter int         SAMPLE_LOG2 = 16,
    parameter logic [7:0] TARGET      = 8'd128,
    parameter logic [7:0] HYST        = 8'd16,
    parameter int         HOLD_FRAMES = 2,
    parameter logic [3:0] LEVEL_INIT  = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       step_up,
    output logic       step_down,
    output logic [3:0] level,
    output logic [7:0] mean_luma,
    output logic       mean_valid
);

    localparam int              AW        = SAMPLE_LOG2 + 8;
    localparam int              CW        = SAMPLE_LOG2 + 1;
    localparam logic [CW-1:0]   FULL      = {1'b1, {SAMPLE_LOG2{1'b0}}};
    localparam logic [CW-1:0]   LAST      = FULL - CW'(1);
    localparam logic [3:0]      HOLD_INIT = 4'(HOLD_FRAMES);
    localparam logic [8:0]      SUM_HI    = {1'b0, TARGET} + {1'b0, HYST};
    localparam logic [8:0]      LO        = (TARGET >= HYST) ? ({1'b0, TARGET} - {1'b0, HYST}) : 9'd0;
    localparam logic [8:0]      HI        = (SUM_HI > 9'd255) ? 9'd255 : SUM_HI;

    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, HOLD} state_t;

    state_t        state, state_next;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [3:0]    hold_cnt;

    logic [9:0]    luma_sum;
    logic [7:0]    y;
    logic [7:0]    m;
    logic          want_up, want_down;

    logic          start_frame, add_sample, eval_now;
    logic          step_up_d, step_down_d, mean_valid_d;
    logic          hold_load, hold_dec;

    assign luma_sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    assign y         = luma_sum[9:2];
    assign m         = acc[AW-1:SAMPLE_LOG2];
    assign want_up   = ({1'b0, m} < LO) && (level != 4'd15);
    assign want_down = ({1'b0, m} > HI) && (level != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (frame_start) state_next = ACCUM;
                ACCUM: if (!frame_start && pix_valid && cnt == LAST) state_next = EVAL;
                EVAL:  state_next = ((want_up || want_down) && HOLD_FRAMES != 0) ? HOLD : IDLE;
                HOLD:  if (frame_start && hold_cnt == 4'd0) state_next = ACCUM;
                default: state_next = IDLE;
            endcase
        end
    end

    // A frame_start mid-ACCUM restarts the set, so it shares the clear/load path with IDLE.
    always_comb begin
        start_frame  = 1'b0;
        add_sample   = 1'b0;
        eval_now     = 1'b0;
        hold_dec     = 1'b0;
        if (enable) begin
            case (state)
                IDLE:    start_frame = frame_start;
                ACCUM: begin
                    start_frame = frame_start;
                    add_sample  = !frame_start && pix_valid;
                end
                EVAL:    eval_now    = 1'b1;
                HOLD: begin
                    start_frame = frame_start && (hold_cnt == 4'd0);
                    hold_dec    = frame_start && (hold_cnt != 4'd0);
                end
                default: ;
            endcase
        end
        step_up_d    = eval_now && want_up;
        step_down_d  = eval_now && want_down;
        mean_valid_d = eval_now;
        hold_load    = (step_up_d || step_down_d) && (HOLD_FRAMES != 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            hold_cnt   <= 4'd0;
            level      <= LEVEL_INIT;
            mean_luma  <= 8'd0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            mean_valid <= 1'b0;
        end else begin
            step_up    <= step_up_d;
            step_down  <= step_down_d;
            mean_valid <= mean_valid_d;
            if (!enable) begin
                acc      <= '0;
                cnt      <= '0;
                hold_cnt <= 4'd0;
            end else begin
                if (start_frame) begin
                    acc <= pix_valid ? AW'(y) : '0;
                    cnt <= pix_valid ? CW'(1) : '0;
                end else if (add_sample) begin
                    acc <= acc + AW'(y);
                    cnt <= cnt + CW'(1);
                end
                if (eval_now) begin
                    mean_luma <= m;
                    if (want_up)        level <= level + 4'd1;
                    else if (want_down) level <= level - 4'd1;
                end
                if (hold_load)     hold_cnt <= HOLD_INIT;
                else if (hold_dec) hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(step_up && step_down)) else $error("step_up and step_down both high");
            assert (!((step_up || step_down) && !mean_valid)) else $error("step without mean_valid");
        end
    end

endmodule

// File: tb/tb_auto_brightness_ctrl.sv
// Randomized bench for auto_brightness_ctrl: two instances (hold 2 / hold 0) driven by the
// same stimulus, each compared every cycle against a frame-level reference model.
module tb_auto_brightness_ctrl;

    localparam int N   = 16;
    localparam int LO  = 112;
    localparam int HI  = 144;

    logic       clk = 1'b0;
    logic       rst, en, fs, pv;
    logic [7:0] rr, gg, bb;
    logic       su [2];
    logic       sd [2];
    logic       mv [2];
    logic [3:0] lv [2];
    logic [7:0] ml [2];

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int  e_su [2], e_sd [2], e_mv [2], e_lv [2], e_ml [2];
    bit  meas [2], due [2];
    int  skip [2], ssum [2], scnt [2];
    int  hold_of [2] = '{2, 0};
    int  c_up [2], c_dn [2], c_mv [2];

    always #5 clk = ~clk;

    auto_brightness_ctrl #(.SAMPLE_LOG2(4), .HOLD_FRAMES(2)) dut (
        .clk(clk), .reset(rst), .enable(en), .frame_start(fs), .pix_valid(pv),
        .r(rr), .g(gg), .b(bb), .step_up(su[0]), .step_down(sd[0]), .level(lv[0]),
        .mean_luma(ml[0]), .mean_valid(mv[0]));

    auto_brightness_ctrl #(.SAMPLE_LOG2(4), .HOLD_FRAMES(0)) dut_h0 (
        .clk(clk), .reset(rst), .enable(en), .frame_start(fs), .pix_valid(pv),
        .r(rr), .g(gg), .b(bb), .step_up(su[1]), .step_down(sd[1]), .level(lv[1]),
        .mean_luma(ml[1]), .mean_valid(mv[1]));

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int luma();
        return (int'(rr) + 2 * int'(gg) + int'(bb)) / 4;
    endfunction

    task automatic begin_frame(input int k);
        meas[k] = 1'b1;
        ssum[k] = pv ? luma() : 0;
        scnt[k] = pv ? 1 : 0;
    endtask

    // Frame-level view: collect samples of a frame; one cycle after the set fills, judge the mean.
    task automatic model_step(input int k);
        int mean;
        e_su[k] = 0; e_sd[k] = 0; e_mv[k] = 0;
        if (rst) begin
            e_lv[k] = 8; e_ml[k] = 0;
            meas[k] = 0; due[k] = 0; skip[k] = -1; ssum[k] = 0; scnt[k] = 0;
        end else if (!en) begin
            meas[k] = 0; due[k] = 0; skip[k] = -1;
        end else if (due[k]) begin
            due[k]  = 0;
            mean    = ssum[k] / N;
            e_ml[k] = mean;
            e_mv[k] = 1;
            if (mean < LO && e_lv[k] < 15) begin
                e_lv[k]++; e_su[k] = 1;
                if (hold_of[k] > 0) skip[k] = hold_of[k];
            end else if (mean > HI && e_lv[k] > 0) begin
                e_lv[k]--; e_sd[k] = 1;
                if (hold_of[k] > 0) skip[k] = hold_of[k];
            end
        end else if (skip[k] >= 0) begin
            if (fs) begin
                if (skip[k] > 0) skip[k]--;
                else begin skip[k] = -1; begin_frame(k); end
            end
        end else if (fs) begin
            begin_frame(k);
        end else if (meas[k] && pv) begin
            ssum[k] += luma();
            scnt[k]++;
            if (scnt[k] == N) begin meas[k] = 0; due[k] = 1; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("step_up[%0d]", k),    int'(su[k]), e_su[k]);
            chk($sformatf("step_down[%0d]", k),  int'(sd[k]), e_sd[k]);
            chk($sformatf("mean_valid[%0d]", k), int'(mv[k]), e_mv[k]);
            chk($sformatf("level[%0d]", k),      int'(lv[k]), e_lv[k]);
            chk($sformatf("mean_luma[%0d]", k),  int'(ml[k]), e_ml[k]);
            if (su[k]) c_up[k]++;
            if (sd[k]) c_dn[k]++;
            if (mv[k]) c_mv[k]++;
        end
    endtask

    task automatic set_px(input int lo, input int hi);
        rr = 8'($urandom_range(lo, hi));
        gg = 8'($urandom_range(lo, hi));
        bb = 8'($urandom_range(lo, hi));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            fs = 0; pv = 0; set_px(0, 255);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1; idle(1); rst = 0;
    endtask

    // frame_start pulse then n pixels in [lo,hi]; rnd adds gaps, enable drops and a pixel on the fs cycle
    task automatic frame(input int n, input int lo, input int hi, input bit rnd);
        int sent = 0;
        fs = 1; pv = 0; set_px(lo, hi);
        if (rnd && $urandom_range(0, 1) == 1) begin pv = 1; sent = 1; end
        tick();
        fs = 0;
        while (sent < n) begin
            if (rnd && $urandom_range(0, 3) == 0) idle(1);
            if (rnd && $urandom_range(0, 60) == 0) begin
                en = 0; idle(1); en = 1;
            end
            pv = 1; set_px(lo, hi);
            tick();
            pv = 0;
            sent++;
        end
        pv = 0;
    endtask

    initial begin
        int up0, dn1, mv0, mv1, up1, lo_v, hi_v;
        for (int k = 0; k < 2; k++) begin c_up[k] = 0; c_dn[k] = 0; c_mv[k] = 0; end
        rst = 1; en = 1; fs = 0; pv = 0; rr = 0; gg = 0; bb = 0;
        idle(2);
        rst = 0;

        // reset state
        idle(5);
        chk("t1_level", int'(lv[0]), 8);
        chk("t1_step_up", int'(su[0]), 0);
        chk("t1_step_down", int'(sd[0]), 0);
        chk("t1_mean_valid", int'(mv[0]), 0);
        chk("t1_mean_luma", int'(ml[0]), 0);

        // dark frame: latency of the result pulses
        frame(N, 40, 40, 0);
        chk("t2_mv_at_e0", int'(mv[0]), 0);
        idle(1);
        chk("t2_mv_at_e1", int'(mv[0]), 1);
        chk("t2_up_at_e1", int'(su[0]), 1);
        chk("t2_mean", int'(ml[0]), 40);
        idle(1);
        chk("t2_mv_one_cycle", int'(mv[0]), 0);
        chk("t2_up_one_cycle", int'(su[0]), 0);
        chk("t2_level", int'(lv[0]), 9);

        // hold: two frame_starts ignored, third measured, then no hold after an in-band frame
        mv0 = c_mv[0];
        frame(N, 128, 128, 0); idle(2);
        frame(N, 128, 128, 0); idle(2);
        chk("t5_ignored", c_mv[0] - mv0, 0);
        up0 = c_up[0];
        frame(N, 128, 128, 0); idle(2);
        chk("t5_measured", c_mv[0] - mv0, 1);
        chk("t3_no_step", c_up[0] - up0, 0);
        chk("t3_level", int'(lv[0]), 9);
        frame(N, 128, 128, 0); idle(2);
        chk("t3_no_hold", c_mv[0] - mv0, 2);

        // bright frames walk the hold-free instance down to 0 and stop there
        do_reset();
        dn1 = c_dn[1]; mv1 = c_mv[1];
        for (int f = 0; f < 9; f++) begin frame(N, 250, 250, 0); idle(2); end
        chk("t4_down_pulses", c_dn[1] - dn1, 8);
        chk("t4_mv_pulses", c_mv[1] - mv1, 9);
        chk("t4_level_floor", int'(lv[1]), 0);

        // partial frame restarted by a new frame_start
        mv1 = c_mv[1];
        frame(10, 0, 0, 0);
        frame(N, 128, 128, 0); idle(2);
        chk("t6_restart_mv", c_mv[1] - mv1, 1);
        chk("t6_restart_mean", int'(ml[1]), 128);

        // enable drop mid-accumulation abandons the frame
        mv0 = c_mv[0]; mv1 = c_mv[1]; up1 = c_up[1];
        frame(8, 0, 0, 0);
        en = 0; idle(3); en = 1;
        for (int i = 0; i < 12; i++) begin pv = 1; set_px(0, 0); tick(); end
        pv = 0; idle(2);
        chk("t6_en_mv0", c_mv[0] - mv0, 0);
        chk("t6_en_mv1", c_mv[1] - mv1, 0);
        chk("t6_en_up1", c_up[1] - up1, 0);

        // reset while holding returns to IDLE at LEVEL_INIT
        do_reset();
        frame(N, 0, 0, 0); idle(2);
        chk("t6_pre_hold_level", int'(lv[0]), 9);
        frame(4, 0, 0, 0);
        do_reset();
        chk("t6_rst_level", int'(lv[0]), 8);
        mv0 = c_mv[0];
        frame(N, 128, 128, 0); idle(2);
        chk("t6_rst_idle_mv", c_mv[0] - mv0, 1);

        // randomized frames, enable drops, early frame_starts, occasional reset
        for (int f = 0; f < 60; f++) begin
            lo_v = $urandom_range(0, 255);
            hi_v = (lo_v + $urandom_range(0, 60) > 255) ? 255 : lo_v + $urandom_range(0, 60);
            frame(($urandom_range(0, 5) == 0) ? $urandom_range(3, 15) : N, lo_v, hi_v, 1);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 25) == 0) do_reset();
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
